// File: rtl/vedic_seq_16x16.sv
// Iterative 16x16 multiplier: one vedic 8x8 core reused over four partial-product steps.
// Optional two's-complement mode is enabled with `define VEDIC_SEQ_SIGNED_EN.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic carry;
  assign carry = a[1] & b[0] & a[0] & b[1];
  assign p[0]  = a[0] & b[0];
  assign p[1]  = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2]  = (a[1] & b[1]) ^ carry;
  assign p[3]  = a[1] & b[1] & carry;
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] pp0, pp1, pp2, pp3;
  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(pp0));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(pp1));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(pp2));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(pp3));
  assign p = {4'b0, pp0} + {2'b0, pp1, 2'b0} + {2'b0, pp2, 2'b0} + {pp3, 4'b0};
endmodule

module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] pp0, pp1, pp2, pp3;
  vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(pp0));
  vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(pp1));
  vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(pp2));
  vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(pp3));
  assign p = {8'b0, pp0} + {4'b0, pp1, 4'b0} + {4'b0, pp2, 4'b0} + {pp3, 8'b0};
endmodule

module vedic_seq_16x16 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [15:0] io_a,
  input  logic [15:0] io_b,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_c,
  output logic        io_busy
`ifdef VEDIC_SEQ_SIGNED_EN
  ,
  input  logic        io_signed
`endif
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // io_c is held stable while io_out_valid is high and io_out_ready is low.
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, nxt_state;
  logic [1:0]  step, nxt_step;
  logic [31:0] acc, nxt_acc;
  logic [15:0] a_r, b_r, nxt_a, nxt_b;
  logic [7:0]  op_a, op_b;
  logic [15:0] prod;
  logic [31:0] addend, sum;
  logic [15:0] in_a, in_b;
  logic        accept;

`ifdef VEDIC_SEQ_SIGNED_EN
  logic sign_r, nxt_sign, in_sign;
  // Magnitudes of 0x8000 stay 0x8000, which is the correct unsigned magnitude.
  assign in_a    = (io_signed && io_a[15]) ? 16'(-io_a) : io_a;
  assign in_b    = (io_signed && io_b[15]) ? 16'(-io_b) : io_b;
  assign in_sign = io_signed & (io_a[15] ^ io_b[15]);
`else
  assign in_a = io_a;
  assign in_b = io_b;
`endif

  // step[0] picks the high byte of a, step[1] the high byte of b.
  assign op_a = step[0] ? a_r[15:8] : a_r[7:0];
  assign op_b = step[1] ? b_r[15:8] : b_r[7:0];

  vedic_8x8 u_core (.a(op_a), .b(op_b), .p(prod));

  always_comb begin
    addend = 32'b0;
    case (step)
      2'd0:    addend = {16'b0, prod};
      2'd1,
      2'd2:    addend = {8'b0, prod, 8'b0};
      default: addend = {prod, 16'b0};
    endcase
  end

  assign sum          = acc + addend;
  assign io_in_ready  = (state == IDLE) || ((state == DONE) && io_out_ready);
  assign io_out_valid = (state == DONE);
  assign io_busy      = (state == CALC);
  assign io_c         = acc;
  assign accept       = io_in_valid && io_in_ready;

  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    nxt_acc   = acc;
    nxt_a     = a_r;
    nxt_b     = b_r;
`ifdef VEDIC_SEQ_SIGNED_EN
    nxt_sign  = sign_r;
`endif
    case (state)
      CALC: begin
        nxt_acc  = sum;
        nxt_step = step + 2'd1;
        if (step == 2'd3) begin
          nxt_state = DONE;
`ifdef VEDIC_SEQ_SIGNED_EN
          if (sign_r) nxt_acc = 32'd0 - sum;
`endif
        end
      end
      DONE: begin
        if (!accept && io_out_ready) nxt_state = IDLE;
      end
      default: ;
    endcase
    // Accept overrides everything above, including the retire in DONE.
    if (accept) begin
      nxt_state = CALC;
      nxt_step  = 2'd0;
      nxt_acc   = 32'b0;
      nxt_a     = in_a;
      nxt_b     = in_b;
`ifdef VEDIC_SEQ_SIGNED_EN
      nxt_sign  = in_sign;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      step   <= 2'd0;
      acc    <= 32'b0;
      a_r    <= 16'b0;
      b_r    <= 16'b0;
`ifdef VEDIC_SEQ_SIGNED_EN
      sign_r <= 1'b0;
`endif
    end else begin
      state  <= nxt_state;
      step   <= nxt_step;
      acc    <= nxt_acc;
      a_r    <= nxt_a;
      b_r    <= nxt_b;
`ifdef VEDIC_SEQ_SIGNED_EN
      sign_r <= nxt_sign;
`endif
    end
  end
endmodule
